apb_event_writer: RTL and testbench
===================================

Name: apb_event_writer

Overview:
- Parametrised successor to the three-event APB notifier; supports NUM_CH event channels.
- Each event pulse increments a per-channel saturating pending counter.
- A round-robin arbiter picks one channel with a non-zero count and issues one APB write to that channel's address. The write data is the number of events being reported.
- Sits between event sources and the APB interconnect as the APB requester; supports PREADY wait states and back-to-back transfers.

Parameters:
- NUM_CH, 3, number of event channels (1..16)
- CNT_W, 4, pending counter width; counter saturates at 2^CNT_W-1
- ADDR_W, 32, APB address width
- DATA_W, 32, APB write data width (must be >= CNT_W)
- BASE_ADDR, 32'hCAFE_0000, address of channel 0
- ADDR_STRIDE, 32'h0001_0000, address increment per channel

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- event_i  in  NUM_CH  one-cycle event pulses, one bit per channel
- apb_psel_o  out  1  APB PSEL
- apb_penable_o  out  1  APB PENABLE
- apb_pwrite_o  out  1  APB PWRITE
- apb_paddr_o  out  ADDR_W  APB PADDR
- apb_pwdata_o  out  DATA_W  APB PWDATA
- apb_pready_i  in  1  APB PREADY
- busy_o  out  1  high when any counter is non-zero or a transfer is in flight
- ovf_o  out  NUM_CH  sticky per-channel saturation flag

Behaviour:
- Reset: reset, asynchronous, active-low; clock clk, rising edge. While reset is low:
  - all counters = 0, ovf_o = 0, state = IDLE, rr pointer = 0
  - psel, penable, pwrite = 0; paddr, pwdata = 0
- Reset mid-transfer aborts the transfer immediately, with no completion.
- Counter update, each edge:
  - cnt[i] += event_i[i].
  - At saturation the counter holds its value, ovf_o[i] is set, and the event is dropped.
  - ovf_o[i] clears only on reset.
- FSM states and transitions:
  - IDLE: if any cnt != 0, grant and go to SETUP; otherwise stay in IDLE.
  - SETUP: psel = 1, penable = 0; always go to ACCESS next.
  - ACCESS: psel = 1, penable = 1.
    - pready = 0: stay in ACCESS; paddr and pwdata are held stable.
    - pready = 1: transfer completes. If any cnt != 0 (including newly arrived events), grant again and go to SETUP. Otherwise go to IDLE.
- Grant on the edge entering SETUP:
  - gnt = first channel with cnt != 0, searching from the rr pointer upward with wrap-around.
  - Registered: paddr = BASE_ADDR + gnt*ADDR_STRIDE; pwdata = zero-extended cnt[gnt].
  - cnt[gnt] becomes event_i[gnt] (0 or 1). A same-cycle event is never lost.
  - rr pointer = (gnt+1) mod NUM_CH.
- pwrite = 1 in both SETUP and ACCESS; 0 otherwise.
- Latency: event sampled at edge N, so cnt = 1 after N. SETUP starts at edge N+1; psel is visible in cycle N+1.
- Throughput: 2 cycles per write with zero wait states; back-to-back without an IDLE gap.
- Simultaneous events on several channels: each gets its own write, in round-robin order.
- No PSLVERR support; responses are not checked.
- busy_o = (state != IDLE) | (|cnt).

Decomposition:
- Shared package apb_evt_pkg holds:
  - state enum/localparams: IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10
  - default BASE_ADDR and ADDR_STRIDE constants
- Sub-module rr_arbiter (parameter N):
  - inputs: req vector, pointer
  - outputs: one-hot grant, grant index, valid
  - purely combinational
- Counters and FSM live in the top module.

Test Plan:
- Single event: event_i = 3'b010 for 1 cycle, pready = 1 → SETUP next cycle; paddr = 32'hCAFF_0000, pwdata = 1; one ACCESS cycle, then IDLE, busy_o = 0.
- Simultaneous events: event_i = 3'b111 for 1 cycle → three back-to-back writes to CAFE_0000, CAFF_0000, CB00_0000, each pwdata = 1, 6 cycles total, no IDLE gap.
- Wait states: channel 0 write with pready low for 3 ACCESS cycles → paddr and pwdata stable for all 4 ACCESS cycles; completion on the 4th.
  - Events on channel 0 during the stall accumulate; a second write follows with pwdata = 3.
- Saturation: 20 consecutive ch2 events while pready is held 0 on a ch0 write → ovf_o[2] = 1; later ch2 write has pwdata = 15.
- Event on grant edge: ch1 event coincides with the grant of ch1 (cnt = 2) → write pwdata = 2; a follow-up write reports pwdata = 1.
- Async reset mid-ACCESS: drive reset low → psel, penable and busy_o drop to 0 immediately (no clock edge); counters and ovf_o are 0 after release.

Source files
------------

// File: rtl/apb_evt_pkg.sv
// Shared definitions for the APB event writer.
//   state_e         : requester FSM encoding (IDLE / SETUP / ACCESS)
//   DEF_BASE_ADDR   : default address of channel 0
//   DEF_ADDR_STRIDE : default address step between consecutive channels
package apb_evt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } state_e;

   localparam logic [31:0] DEF_BASE_ADDR   = 32'hCAFE_0000;
   localparam logic [31:0] DEF_ADDR_STRIDE = 32'h0001_0000;

endpackage

// File: rtl/apb_event_writer_if.sv
// APB write-requester bundle for the event writer.
//   psel, penable, pwrite, paddr, pwdata : driven by the requester
//   pready                               : driven by the completer
// master modport = requester side, slave modport = completer side.
interface apb_event_writer_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pready;

   modport master (output psel, penable, pwrite, paddr, pwdata, input  pready);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata, output pready);
endinterface

// File: rtl/apb_event_writer_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i     : request vector, one bit per requester
//   ptr_i     : index where the search starts (highest priority)
//   gnt_oh_o  : one-hot grant
//   gnt_idx_o : index of the granted requester
//   valid_o   : at least one request present
module rr_arbiter #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_oh_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             valid_o
);

   logic             found;
   logic [IDX_W-1:0] sel;
   int unsigned      idx;

   // NOTE: every variable gets a default at the top of always_comb so no path
   // leaves it unassigned, which is what would otherwise infer a latch.
   always_comb begin
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      sel       = '0;
      idx       = 0;
      // Walk the requesters starting at the pointer, wrapping past N-1.
      for (int off = 0; off < N; off++) begin
         idx = (int'(ptr_i) + off) % N;
         sel = IDX_W'(idx);
         if (!found && req_i[sel]) begin
            found          = 1'b1;
            gnt_idx_o      = sel;
            gnt_oh_o[sel]  = 1'b1;
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/apb_event_writer.sv
// APB event writer: counts per-channel event pulses in saturating counters and
// reports them as APB writes, one channel per transfer, in round-robin order.
//   clk, reset    : clock, asynchronous active-low reset
//   event_i       : one-cycle event pulses, one bit per channel
//   apb_*         : APB requester signals (PREADY wait states supported)
//   busy_o        : a transfer is in flight or events are still pending
//   ovf_o         : sticky per-channel flag, set when an event hit a full counter
import apb_evt_pkg::*;

module apb_event_writer #(
   parameter int unsigned       NUM_CH      = 3,
   parameter int unsigned       CNT_W       = 4,
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
   parameter logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(DEF_ADDR_STRIDE)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] event_i,
   output logic              apb_psel_o,
   output logic              apb_penable_o,
   output logic              apb_pwrite_o,
   output logic [ADDR_W-1:0] apb_paddr_o,
   output logic [DATA_W-1:0] apb_pwdata_o,
   input  logic              apb_pready_i,
   output logic              busy_o,
   output logic [NUM_CH-1:0] ovf_o
);

   localparam int unsigned      IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q [NUM_CH];
   logic [CNT_W-1:0]    cnt_d [NUM_CH];
   logic [NUM_CH-1:0]   ovf_q, ovf_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;

   logic [NUM_CH-1:0]   req;
   logic [NUM_CH-1:0]   gnt_oh;
   logic [IDX_W-1:0]    gnt_idx;
   logic                gnt_valid;
   logic                grant_en;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) req[i] = (cnt_q[i] != '0);
   end

   rr_arbiter #(.N(NUM_CH), .IDX_W(IDX_W)) u_arb (
      .req_i     (req),
      .ptr_i     (rr_q),
      .gnt_oh_o  (gnt_oh),
      .gnt_idx_o (gnt_idx),
      .valid_o   (gnt_valid)
   );

   // A grant is taken on every edge that enters SETUP: from IDLE, or straight
   // out of a completing ACCESS so back-to-back writes have no IDLE gap.
   assign grant_en = gnt_valid &&
                     ((state_q == IDLE) || ((state_q == ACCESS) && apb_pready_i));

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (gnt_valid) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (apb_pready_i) state_d = gnt_valid ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      apb_psel_o    = (state_q != IDLE);
      apb_penable_o = (state_q == ACCESS);
      apb_pwrite_o  = (state_q != IDLE);
   end

   // ---------------- counters and overflow flags ----------------
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_en && gnt_oh[i]) begin
            // The granted count is being reported; a same-edge event restarts at 1.
            cnt_d[i] = CNT_W'(event_i[i]);
         end else if (event_i[i]) begin
            if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
            else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // ---------------- grant datapath ----------------
   always_comb begin
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      rr_d     = rr_q;
      if (grant_en) begin
         paddr_d  = BASE_ADDR + ADDR_W'(gnt_idx) * ADDR_STRIDE;
         pwdata_d = DATA_W'(cnt_q[gnt_idx]);
         rr_d     = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   // NOTE: the counter array is reset alongside the scalar flops because the
   // pending counts must start at zero; it is a register file, not a RAM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
         ovf_q    <= '0;
         rr_q     <= '0;
         paddr_q  <= '0;
         pwdata_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         rr_q     <= rr_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
      end
   end

   assign apb_paddr_o  = paddr_q;
   assign apb_pwdata_o = pwdata_q;
   assign ovf_o        = ovf_q;
   assign busy_o       = (state_q != IDLE) | gnt_valid;

endmodule

// File: tb/tb_apb_event_writer.sv
// Self-checking bench for apb_event_writer (NUM_CH=3, CNT_W=4, defaults).
// Expected writes are queued by each scenario; a negedge monitor pops and
// compares them at every completed APB transfer and checks address/data hold
// during wait states.
module tb_apb_event_writer;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [2:0] event_i;
   logic       busy_o;
   logic [2:0] ovf_o;

   int total = 0;
   int bad   = 0;

   exp_t exp_q[$];
   exp_t e_mon;
   logic        hold_vld;
   logic [31:0] hold_addr, hold_data;

   apb_event_writer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_event_writer dut (
      .clk           (clk),
      .reset         (reset),
      .event_i       (event_i),
      .apb_psel_o    (bus.psel),
      .apb_penable_o (bus.penable),
      .apb_pwrite_o  (bus.pwrite),
      .apb_paddr_o   (bus.paddr),
      .apb_pwdata_o  (bus.pwdata),
      .apb_pready_i  (bus.pready),
      .busy_o        (busy_o),
      .ovf_o         (ovf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   // Monitor: the negedge is mid-cycle, so pready is the value that the next
   // rising edge will sample.
   always @(negedge clk) begin
      if (!reset) begin
         hold_vld = 1'b0;
      end else begin
         if (bus.psel && !bus.penable) begin
            hold_vld  = 1'b1;
            hold_addr = bus.paddr;
            hold_data = bus.pwdata;
         end
         if (bus.psel && bus.penable && hold_vld) begin
            total++;
            if (bus.paddr !== hold_addr || bus.pwdata !== hold_data) begin
               bad++;
               $display("FAIL access_hold addr=%h data=%h required addr=%h data=%h",
                        bus.paddr, bus.pwdata, hold_addr, hold_data);
            end
         end
         if (bus.psel && bus.penable && bus.pready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write addr=%h data=%h", bus.paddr, bus.pwdata);
            end else begin
               e_mon = exp_q.pop_front();
               if (bus.paddr !== e_mon.addr || bus.pwdata !== e_mon.data || bus.pwrite !== 1'b1) begin
                  bad++;
                  $display("FAIL write_data addr=%h data=%h pwrite=%b required addr=%h data=%h pwrite=1",
                           bus.paddr, bus.pwdata, bus.pwrite, e_mon.addr, e_mon.data);
               end
            end
            hold_vld = 1'b0;
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      event_i   = '0;
      bus.pready = 1'b1;
      step(2);
      exp_q.delete();
      reset = 1'b1;
      step(1);
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 200; k++) begin
         if (!busy_o) break;
         step(1);
      end
      total++;
      if (busy_o !== 1'b0) begin
         bad++;
         $display("FAIL %s_idle_timeout busy=%b required 0", name, busy_o);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_missing_writes pending=%0d required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      event_i    = '0;
      bus.pready = 1'b1;
      step(2);
      total++;
      if ({bus.psel, bus.penable, bus.pwrite, busy_o} !== 4'b0000 || bus.paddr !== 32'h0 ||
          bus.pwdata !== 32'h0 || ovf_o !== 3'b000) begin
         bad++;
         $display("FAIL reset_state psel=%b pen=%b pw=%b busy=%b addr=%h data=%h ovf=%b required all 0",
                  bus.psel, bus.penable, bus.pwrite, busy_o, bus.paddr, bus.pwdata, ovf_o);
      end
      reset = 1'b1;
      step(1);
   endtask

   task automatic test_single();
      do_reset();
      exp_q.push_back('{addr: 32'hCAFF_0000, data: 32'd1});
      event_i = 3'b010;
      step(1);                       // edge N samples the event
      event_i = '0;
      total++;
      if (busy_o !== 1'b1 || bus.psel !== 1'b0) begin
         bad++;
         $display("FAIL single_pending busy=%b psel=%b required busy=1 psel=0", busy_o, bus.psel);
      end
      step(1);                       // edge N+1: SETUP
      total++;
      if ({bus.psel, bus.penable, bus.pwrite} !== 3'b101 || bus.paddr !== 32'hCAFF_0000 ||
          bus.pwdata !== 32'd1) begin
         bad++;
         $display("FAIL single_setup sel/en/wr=%b%b%b addr=%h data=%h required 101 CAFF0000 1",
                  bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata);
      end
      step(1);
      total++;
      if ({bus.psel, bus.penable} !== 2'b11) begin
         bad++;
         $display("FAIL single_access sel/en=%b%b required 11", bus.psel, bus.penable);
      end
      step(1);
      total++;
      if ({bus.psel, bus.penable, bus.pwrite, busy_o} !== 4'b0000) begin
         bad++;
         $display("FAIL single_back_idle sel/en/wr/busy=%b%b%b%b required 0000",
                  bus.psel, bus.penable, bus.pwrite, busy_o);
      end
      wait_idle("single");
   endtask

   task automatic test_back_to_back();
      logic [5:0] sel_seen, en_seen;
      do_reset();
      exp_q.push_back('{addr: 32'hCAFE_0000, data: 32'd1});
      exp_q.push_back('{addr: 32'hCAFF_0000, data: 32'd1});
      exp_q.push_back('{addr: 32'hCB00_0000, data: 32'd1});
      event_i = 3'b111;
      step(1);
      event_i = '0;
      for (int c = 0; c < 6; c++) begin
         step(1);
         sel_seen[c] = bus.psel;
         en_seen[c]  = bus.penable;
      end
      total++;
      if (sel_seen !== 6'b111111 || en_seen !== 6'b101010) begin
         bad++;
         $display("FAIL b2b_phases psel=%b penable=%b required 111111 101010", sel_seen, en_seen);
      end
      step(1);
      total++;
      if (bus.psel !== 1'b0 || busy_o !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end psel=%b busy=%b required 0 0", bus.psel, busy_o);
      end
      wait_idle("b2b");
   endtask

   task automatic test_wait_states();
      do_reset();
      exp_q.push_back('{addr: 32'hCAFE_0000, data: 32'd1});
      exp_q.push_back('{addr: 32'hCAFE_0000, data: 32'd3});
      bus.pready = 1'b0;
      event_i    = 3'b001;
      step(1);
      event_i = '0;
      step(1);                       // SETUP
      event_i = 3'b001;              // three ch0 events during the stall
      step(3);
      event_i = '0;
      step(1);                       // fourth ACCESS cycle
      total++;
      if ({bus.psel, bus.penable} !== 2'b11 || bus.pwdata !== 32'd1) begin
         bad++;
         $display("FAIL wait_stalled sel/en=%b%b data=%h required 11 1", bus.psel, bus.penable, bus.pwdata);
      end
      bus.pready = 1'b1;
      step(1);                       // completion, straight into SETUP
      total++;
      if ({bus.psel, bus.penable} !== 2'b10 || bus.pwdata !== 32'd3) begin
         bad++;
         $display("FAIL wait_second_setup sel/en=%b%b data=%h required 10 3",
                  bus.psel, bus.penable, bus.pwdata);
      end
      wait_idle("wait");
   endtask

   task automatic test_saturation();
      do_reset();
      exp_q.push_back('{addr: 32'hCAFE_0000, data: 32'd1});
      exp_q.push_back('{addr: 32'hCB00_0000, data: 32'd15});
      bus.pready = 1'b0;
      event_i    = 3'b001;
      step(1);
      event_i = 3'b100;
      step(14);                      // 14 ch2 events: count 14, not yet full
      total++;
      if (ovf_o !== 3'b000) begin
         bad++;
         $display("FAIL sat_early_ovf ovf=%b required 000", ovf_o);
      end
      step(6);                       // 20 events total
      event_i = '0;
      total++;
      if (ovf_o !== 3'b100) begin
         bad++;
         $display("FAIL sat_ovf ovf=%b required 100", ovf_o);
      end
      bus.pready = 1'b1;
      wait_idle("sat");
      total++;
      if (ovf_o !== 3'b100) begin
         bad++;
         $display("FAIL sat_ovf_sticky ovf=%b required 100", ovf_o);
      end
   endtask

   task automatic test_grant_edge();
      do_reset();
      exp_q.push_back('{addr: 32'hCAFE_0000, data: 32'd1});
      exp_q.push_back('{addr: 32'hCAFF_0000, data: 32'd2});
      exp_q.push_back('{addr: 32'hCAFF_0000, data: 32'd1});
      bus.pready = 1'b0;
      event_i    = 3'b001;
      step(1);
      event_i = '0;
      step(1);                       // ch0 SETUP
      event_i = 3'b010;
      step(2);                       // ch1 count reaches 2
      bus.pready = 1'b1;
      step(1);                       // completion edge == ch1 grant edge == ch1 event
      event_i = '0;
      total++;
      if (bus.paddr !== 32'hCAFF_0000 || bus.pwdata !== 32'd2 || bus.penable !== 1'b0) begin
         bad++;
         $display("FAIL edge_grant addr=%h data=%h pen=%b required CAFF0000 2 0",
                  bus.paddr, bus.pwdata, bus.penable);
      end
      wait_idle("edge");
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.pready = 1'b0;
      event_i    = 3'b101;
      exp_q.push_back('{addr: 32'hCAFE_0000, data: 32'd1});   // aborted, flushed below
      step(1);
      event_i = 3'b100;
      step(18);                      // ch0 write stuck in ACCESS, ch2 saturated
      event_i = '0;
      total++;
      if ({bus.psel, bus.penable} !== 2'b11 || ovf_o !== 3'b100) begin
         bad++;
         $display("FAIL areset_pre sel/en=%b%b ovf=%b required 11 100", bus.psel, bus.penable, ovf_o);
      end
      #2;                            // mid-cycle, no clock edge
      reset = 1'b0;
      #1;
      total++;
      if ({bus.psel, bus.penable, busy_o} !== 3'b000) begin
         bad++;
         $display("FAIL areset_drop sel/en/busy=%b%b%b required 000", bus.psel, bus.penable, busy_o);
      end
      exp_q.delete();
      bus.pready = 1'b1;
      step(2);
      reset = 1'b1;
      step(3);
      total++;
      if (ovf_o !== 3'b000 || busy_o !== 1'b0 || bus.psel !== 1'b0) begin
         bad++;
         $display("FAIL areset_after ovf=%b busy=%b psel=%b required 000 0 0", ovf_o, busy_o, bus.psel);
      end
   endtask

   initial begin
      hold_vld = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_wait_states();
      test_saturation();
      test_grant_edge();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
